// File: rtl/uart_tx_framer.sv
// uart_tx_framer: byte-to-UART frame serializer (start, LSB-first data, optional even parity, stop).
module uart_tx_framer #(
  parameter int DATA_BITS   = 8,
  parameter int PERIOD_BITS = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PERIOD_BITS-1:0] bit_period,
  input  logic                   parity_en,
  input  logic [DATA_BITS-1:0]   data_in,
  input  logic                   tx_start,
  output logic                   tx_ready,
  output logic                   tx_out,
  output logic                   tx_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  state_t                 state_q, state_d;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   par_q, par_d, tx_q, tx_d, roll, accept;
  assign roll     = cnt_q == period_q;
  assign tx_done  = (state_q == STOP) && roll;
  assign tx_ready = (state_q == IDLE) || tx_done;
  assign accept   = tx_start && tx_ready;
  assign tx_out   = tx_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      period_q <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      period_q <= period_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == IDLE) ? '0 : roll ? PERIOD_BITS'(1) : cnt_q + 1'b1;
    idx_d    = idx_q;
    data_d   = data_q;
    period_d = period_q;
    par_d    = par_q;
    if (accept) begin
      state_d  = START;
      cnt_d    = PERIOD_BITS'(1);
      idx_d    = '0;
      data_d   = data_in;
      period_d = (bit_period < PERIOD_BITS'(2)) ? PERIOD_BITS'(2) : bit_period;
      par_d    = parity_en;
    end else if (roll) begin
      case (state_q)
        START:  begin state_d = DATA; idx_d = '0; end
        DATA: begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(DATA_BITS - 1)) state_d = par_q ? PARITY : STOP;
        end
        PARITY: state_d = STOP;
        STOP:   state_d = IDLE;
        default: ;
      endcase
    end
  end
  // Line level is registered from the next state so each bit appears on the edge it begins.
  always_comb begin
    tx_d = (state_d == START)  ? 1'b0 :
           (state_d == DATA)   ? data_q[idx_d] :
           (state_d == PARITY) ? ^data_q : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed scenario tasks checking uart_tx_framer line, ready and done timing.
module tb_uart_tx_framer;
  logic        clk = 1'b0, rst = 1'b1, parity_en = 1'b0, tx_start = 1'b0;
  logic        tx_ready, tx_out, tx_done;
  logic [13:0] bit_period = 14'd4;
  logic [7:0]  data_in = 8'h00;
  int          tests = 0, fails = 0;
  logic        ln [0:63];
  logic        rd [0:63];
  logic        dn [0:63];
  uart_tx_framer dut (
    .clk(clk), .rst(rst), .bit_period(bit_period), .parity_en(parity_en),
    .data_in(data_in), .tx_start(tx_start), .tx_ready(tx_ready),
    .tx_out(tx_out), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  function automatic logic exp_bit(input int i, input logic [7:0] d, input logic par, input int p);
    int b;
    b = i / p;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par && b == 9) return ^d;
    return 1'b1;
  endfunction
  task automatic launch(input logic [7:0] d, input int p, input logic par);
    @(negedge clk);
    data_in    = d;
    bit_period = 14'(p);
    parity_en  = par;
    tx_start   = 1'b1;
  endtask
  // Sample index i corresponds to frame clock i+1 after the accepting edge.
  task automatic capture(input int n, input int hold, input int chg_at, input logic [7:0] chg_d,
                         input int chg_p, input logic chg_pulse);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ln[i] = tx_out;
      rd[i] = tx_ready;
      dn[i] = tx_done;
      tx_start = (i < hold - 1) || (chg_pulse && i == chg_at);
      if (i == chg_at) begin
        data_in    = chg_d;
        bit_period = 14'(chg_p);
      end
    end
    tx_start = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tx_start = 1'b0;
    repeat (2) @(negedge clk);
    tests += 3;
    if (tx_out !== 1'b1)   begin fails++; $display("FAIL reset_tx_out: got %b want 1", tx_out); end
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    if (tx_done !== 1'b0)  begin fails++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    rst = 1'b0;
    launch(8'hA5, 4, 1'b0);
    capture(10, 1, -1, 8'h00, 0, 1'b0);
    tests++;
    if (ln[9] !== 1'b0) begin fails++; $display("FAIL pre_abort_line: got %b want 0", ln[9]); end
    rst = 1'b1;
    @(negedge clk);
    tests += 3;
    if (tx_out !== 1'b1)   begin fails++; $display("FAIL abort_tx_out: got %b want 1", tx_out); end
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL abort_tx_ready: got %b want 1", tx_ready); end
    if (tx_done !== 1'b0)  begin fails++; $display("FAIL abort_tx_done: got %b want 0", tx_done); end
    @(negedge clk);
    rst = 1'b0;
    capture(30, 0, -1, 8'h00, 0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tests++;
      if (dn[i] !== 1'b0 || ln[i] !== 1'b1) begin
        fails++;
        $display("FAIL abort_quiet[%0d]: got done=%b line=%b want done=0 line=1", i, dn[i], ln[i]);
      end
    end
  endtask
  task automatic test_basic();
    launch(8'hA5, 4, 1'b0);
    capture(44, 1, -1, 8'h00, 0, 1'b0);
    for (int i = 0; i < 44; i++) begin
      tests += 3;
      if (ln[i] !== exp_bit(i, 8'hA5, 1'b0, 4)) begin
        fails++; $display("FAIL basic_line[%0d]: got %b want %b", i, ln[i], exp_bit(i, 8'hA5, 1'b0, 4));
      end
      if (rd[i] !== (i >= 39)) begin
        fails++; $display("FAIL basic_ready[%0d]: got %b want %b", i, rd[i], i >= 39);
      end
      if (dn[i] !== (i == 39)) begin
        fails++; $display("FAIL basic_done[%0d]: got %b want %b", i, dn[i], i == 39);
      end
    end
  endtask
  task automatic test_parity();
    logic [7:0] vals [2];
    vals[0] = 8'hA5;
    vals[1] = 8'h07;
    for (int v = 0; v < 2; v++) begin
      launch(vals[v], 3, 1'b1);
      capture(36, 1, -1, 8'h00, 0, 1'b0);
      tests++;
      if (ln[28] !== (v == 1)) begin
        fails++; $display("FAIL parity_bit[%0d]: got %b want %b", v, ln[28], v == 1);
      end
      for (int i = 0; i < 36; i++) begin
        tests += 2;
        if (ln[i] !== exp_bit(i, vals[v], 1'b1, 3)) begin
          fails++; $display("FAIL parity_line[%0d][%0d]: got %b want %b", v, i, ln[i], exp_bit(i, vals[v], 1'b1, 3));
        end
        if (dn[i] !== (i == 32)) begin
          fails++; $display("FAIL parity_done[%0d][%0d]: got %b want %b", v, i, dn[i], i == 32);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic e;
    launch(8'h00, 2, 1'b0);
    capture(44, 21, 0, 8'hFF, 2, 1'b0);
    for (int i = 0; i < 44; i++) begin
      e = (i < 20) ? exp_bit(i, 8'h00, 1'b0, 2) : (i < 40) ? exp_bit(i - 20, 8'hFF, 1'b0, 2) : 1'b1;
      tests += 2;
      if (ln[i] !== e) begin
        fails++; $display("FAIL b2b_line[%0d]: got %b want %b", i, ln[i], e);
      end
      if (dn[i] !== (i == 19 || i == 39)) begin
        fails++; $display("FAIL b2b_done[%0d]: got %b want %b", i, dn[i], i == 19 || i == 39);
      end
    end
  endtask
  task automatic test_ignored();
    launch(8'hA5, 4, 1'b0);
    capture(48, 1, 5, 8'h3C, 8, 1'b1);
    for (int i = 0; i < 48; i++) begin
      tests += 3;
      if (ln[i] !== exp_bit(i, 8'hA5, 1'b0, 4)) begin
        fails++; $display("FAIL ignored_line[%0d]: got %b want %b", i, ln[i], exp_bit(i, 8'hA5, 1'b0, 4));
      end
      if (rd[i] !== (i >= 39)) begin
        fails++; $display("FAIL ignored_ready[%0d]: got %b want %b", i, rd[i], i >= 39);
      end
      if (dn[i] !== (i == 39)) begin
        fails++; $display("FAIL ignored_done[%0d]: got %b want %b", i, dn[i], i == 39);
      end
    end
  endtask
  task automatic test_clamp();
    for (int p = 0; p < 2; p++) begin
      launch(8'h5A, p, 1'b0);
      capture(24, 1, -1, 8'h00, 0, 1'b0);
      for (int i = 0; i < 24; i++) begin
        tests += 2;
        if (ln[i] !== exp_bit(i, 8'h5A, 1'b0, 2)) begin
          fails++; $display("FAIL clamp_line[p=%0d][%0d]: got %b want %b", p, i, ln[i], exp_bit(i, 8'h5A, 1'b0, 2));
        end
        if (dn[i] !== (i == 19)) begin
          fails++; $display("FAIL clamp_done[p=%0d][%0d]: got %b want %b", p, i, dn[i], i == 19);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_ignored();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
